mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle controller for the unsigned-multiply instruction (opcode 7'b0001111, control code 4'hb).
- Accepts operands from the register-read stage and holds the pipeline with a stall signal while it works.
- Runs a shift-add multiply over several cycles, then issues a single-cycle register write-back request.
- Sits beside the ALU. The control unit's 4'hb decode drives its start input.

Parameters:
- XLEN, 32, operand width in bits.
- EARLY_TERM, 1: when 1, stop iterating once no set bits remain in the multiplier. When 0, always run XLEN iterations.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start_i  input  1  request to begin a multiply; asserted when the decoded control code is 4'hb.
- flush_i  input  1  abort the current operation (branch/jump redirect).
- op_a_i  input  XLEN  multiplicand, unsigned.
- op_b_i  input  XLEN  multiplier, unsigned.
- rd_i  input  RD_W  destination register index.
- stall_o  output  1  freezes upstream pipeline stages.
- busy_o  output  1  high whenever the state is not IDLE.
- wb_valid_o  output  1  one-cycle register-write strobe.
- wb_rd_o  output  RD_W  destination index for the write-back.
- result_lo_o  output  XLEN  product bits [XLEN-1:0].
- result_hi_o  output  XLEN  product bits [2*XLEN-1:XLEN].

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - Accumulator, multiplicand, multiplier, counter and rd are cleared.
  - All outputs are 0 from the next cycle.
  - Reset overrides every other input, including mid-RUN. No write-back occurs for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and flush_i=0 at an edge, capture the operands and go to RUN:
    - multiplicand = zero-extended op_a_i (2*XLEN bits)
    - multiplier = op_b_i
    - acc = 0, cnt = 0, rd = rd_i
  - stall_o = start_i & ~flush_i, combinational, so the issuing instruction holds in the same cycle.
- RUN, each cycle:
  - If multiplier[0]=1, acc += multiplicand, modulo 2^(2*XLEN). Overflow is impossible by construction.
  - Then multiplicand <<= 1, multiplier >>= 1, cnt += 1.
  - Exit to DONE when cnt == XLEN-1, or when EARLY_TERM=1 and the shifted multiplier == 0.
  - stall_o = 1.
- DONE (one cycle):
  - wb_valid_o = 1, wb_rd_o = rd, result outputs = acc.
  - stall_o = 0, so the pipeline advances this cycle.
  - Next state is IDLE.
  - result_*_o hold their value until the next start. wb_valid_o is 0 outside DONE.
- Latency (start sampled at edge T):
  - Number of RUN cycles n = XLEN if EARLY_TERM=0.
  - With EARLY_TERM=1, n = max(1, msb_index(op_b)+1); op_b=0 gives n=1.
  - wb_valid_o is high in the cycle after edge T+n.
- start_i while busy: ignored; no queuing.
- flush_i:
  - In RUN: go to IDLE at the next edge; no write-back; stall_o drops in the same cycle, combinationally.
  - In DONE: suppresses wb_valid_o, combinationally.
  - In IDLE with start_i: start is not accepted.
- wb_rd_o = 0 with wb_valid_o = 1 is legal; suppressing x0 writes is the register file's job.
- Back-to-back: start_i may be accepted in the IDLE cycle immediately after DONE. Minimum issue spacing is n+2 cycles.

Test Plan:
- Reset mid-operation: start 7×9, hold rst_n=0 for one edge during RUN cycle 2 → IDLE next cycle; busy_o=0, stall_o=0, no wb_valid_o pulse thereafter.
- Simple product, EARLY_TERM=1: op_a=3, op_b=5, rd=10 → stall_o high for 4 cycles (issue cycle + 3 RUN); then wb_valid_o pulse with result_lo=15, result_hi=0, wb_rd_o=10.
- Full width, EARLY_TERM=0: op_a=op_b=32'hFFFFFFFF → exactly 32 RUN cycles; result_hi=32'hFFFFFFFE, result_lo=32'h00000001.
- Zero multiplier: op_a=123, op_b=0 → n=1, DONE two cycles after issue, result=0. Then start 4×4 in the following IDLE cycle → result_lo=16.
- Flush: start 6×7, assert flush_i in RUN cycle 1 → no wb_valid_o, return to IDLE. start_i asserted in RUN is ignored, and the next start yields a correct fresh product.
- Random: 1000 operand pairs compared against a 64-bit reference product, with latency checked against the n formula for both EARLY_TERM settings.

Source files
------------

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle shift-add unsigned multiply sequencer
module mul_sequencer #(
   parameter int XLEN       = 32,
   parameter bit EARLY_TERM = 1'b1,
   parameter int RD_W       = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [RD_W-1:0] rd_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            wb_valid_o,
   output logic [RD_W-1:0] wb_rd_o,
   output logic [XLEN-1:0] result_lo_o,
   output logic [XLEN-1:0] result_hi_o
);

   localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RD_W-1:0]     rd_q, rd_d;
   logic [XLEN-1:0]     mplier_shift;
   logic                last_iter;

   // Iteration ends after the XLEN-th step, or early once the remaining multiplier bits are all zero.
   always_comb begin
      mplier_shift = mplier_q >> 1;
      last_iter    = (cnt_q == CNT_W'(XLEN - 1)) || (EARLY_TERM && (mplier_shift == '0));
   end

   // Next-state, datapath update and handshake outputs; stall and write strobe react to flush in the same cycle.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      stall_o    = 1'b0;
      wb_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_o = start_i & ~flush_i;
            if (start_i && !flush_i) begin
               mcand_d  = {{XLEN{1'b0}}, op_a_i};
               mplier_d = op_b_i;
               acc_d    = '0;
               cnt_d    = '0;
               rd_d     = rd_i;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               stall_o = 1'b1;
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_shift;
               cnt_d    = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            wb_valid_o = ~flush_i;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
      end
   end

   // The accumulator doubles as the result holding register until the next accepted start.
   always_comb begin
      busy_o      = (state_q != S_IDLE);
      wb_rd_o     = rd_q;
      result_lo_o = acc_q[XLEN-1:0];
      result_hi_o = acc_q[2*XLEN-1:XLEN];
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer, both EARLY_TERM settings
module tb_mul_sequencer;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start_i = 1'b0;
   logic            flush_i = 1'b0;
   logic [XLEN-1:0] op_a_i = '0;
   logic [XLEN-1:0] op_b_i = '0;
   logic [RD_W-1:0] rd_i = '0;

   logic            stall_e1, busy_e1, wbv_e1;
   logic [RD_W-1:0] wbrd_e1;
   logic [XLEN-1:0] lo_e1, hi_e1;
   logic            stall_e0, busy_e0, wbv_e0;
   logic [RD_W-1:0] wbrd_e0;
   logic [XLEN-1:0] lo_e0, hi_e0;

   int n_checks = 0;
   int n_pass   = 0;

   mul_sequencer #(.XLEN(XLEN), .EARLY_TERM(1'b1), .RD_W(RD_W)) dut_e1 (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
      .stall_o(stall_e1), .busy_o(busy_e1), .wb_valid_o(wbv_e1), .wb_rd_o(wbrd_e1),
      .result_lo_o(lo_e1), .result_hi_o(hi_e1)
   );

   mul_sequencer #(.XLEN(XLEN), .EARLY_TERM(1'b0), .RD_W(RD_W)) dut_e0 (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
      .stall_o(stall_e0), .busy_o(busy_e0), .wb_valid_o(wbv_e0), .wb_rd_o(wbrd_e0),
      .result_lo_o(lo_e0), .result_hi_o(hi_e0)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Iteration count from the operand alone: highest set bit position plus one, at least one.
   function automatic int ref_n(input logic [XLEN-1:0] b, input bit et);
      int m;
      if (!et) return XLEN;
      m = 0;
      for (int i = 0; i < XLEN; i++) if (b[i]) m = i + 1;
      return (m == 0) ? 1 : m;
   endfunction

   // Called at a negedge with both units idle; returns at the negedge of the first RUN cycle.
   task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd);
      start_i = 1'b1;
      op_a_i  = a;
      op_b_i  = b;
      rd_i    = rd;
      #1;
      check("issue_stall", {62'd0, stall_e1, stall_e0}, 64'd3);
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 64; i++) begin
         if (!busy_e1 && !busy_e0) break;
         @(negedge clk);
      end
      check(tag, {62'd0, busy_e1, busy_e0}, 64'd0);
   endtask

   task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd);
      int lat1, lat0, pul1, pul0, st1, st0;
      logic [63:0] prod, r1, r0;
      logic [RD_W-1:0] rd1, rd0;
      lat1 = -1; lat0 = -1; pul1 = 0; pul0 = 0; st1 = 0; st0 = 0;
      r1 = 'x; r0 = 'x; rd1 = 'x; rd0 = 'x;
      prod = {32'd0, a} * {32'd0, b};
      issue(a, b, rd);
      for (int k = 0; k < 40; k++) begin
         if (k > 0 && !busy_e1 && !busy_e0) break;
         if (stall_e1) st1++;
         if (stall_e0) st0++;
         if (wbv_e1) begin
            pul1++;
            if (lat1 < 0) begin lat1 = k; r1 = {hi_e1, lo_e1}; rd1 = wbrd_e1; end
         end
         if (wbv_e0) begin
            pul0++;
            if (lat0 < 0) begin lat0 = k; r0 = {hi_e0, lo_e0}; rd0 = wbrd_e0; end
         end
         @(negedge clk);
      end
      check("lat_et1", 64'(lat1), 64'(ref_n(b, 1'b1)));
      check("lat_et0", 64'(lat0), 64'(ref_n(b, 1'b0)));
      check("pulses_et1", 64'(pul1), 64'd1);
      check("pulses_et0", 64'(pul0), 64'd1);
      check("prod_et1", r1, prod);
      check("prod_et0", r0, prod);
      check("rd_et1", 64'(rd1), 64'(rd));
      check("rd_et0", 64'(rd0), 64'(rd));
      check("stall_cyc_et1", 64'(st1), 64'(ref_n(b, 1'b1)));
      check("stall_cyc_et0", 64'(st0), 64'(ref_n(b, 1'b0)));
   endtask

   initial begin
      int pul;
      int lat;
      logic [63:0] r;
      logic [RD_W-1:0] rdv;
      logic [XLEN-1:0] ra, rb;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_outs_e1", {stall_e1, busy_e1, wbv_e1, 59'(wbrd_e1)}, 64'd0);
      check("rst_res_e1", {hi_e1, lo_e1}, 64'd0);
      check("rst_outs_e0", {stall_e0, busy_e0, wbv_e0, 59'(wbrd_e0)}, 64'd0);
      check("rst_res_e0", {hi_e0, lo_e0}, 64'd0);

      // simple product and full-width product
      run_op(32'd3, 32'd5, 5'd10);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
      check("full_hi_e0", 64'(hi_e0), 64'hFFFF_FFFE);
      check("full_lo_e0", 64'(lo_e0), 64'h0000_0001);

      // zero multiplier then back-to-back start on the early-terminating unit
      issue(32'd123, 32'd0, 5'd7);
      @(negedge clk);
      check("zero_wbv", 64'(wbv_e1), 64'd1);
      check("zero_res", {hi_e1, lo_e1}, 64'd0);
      check("zero_rd", 64'(wbrd_e1), 64'd7);
      @(negedge clk);
      check("b2b_idle", 64'(busy_e1), 64'd0);
      start_i = 1'b1; op_a_i = 32'd4; op_b_i = 32'd4; rd_i = 5'd8;
      #1;
      check("b2b_stall", {62'd0, stall_e1, stall_e0}, 64'd3);
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (wbv_e1) begin lat = k; break; end
         @(negedge clk);
      end
      check("b2b_lat", 64'(lat), 64'd3);
      check("b2b_res", {hi_e1, lo_e1}, 64'd16);
      check("b2b_rd", 64'(wbrd_e1), 64'd8);
      r = 'x; rdv = 'x;
      for (int k = 0; k < 40; k++) begin
         if (wbv_e0) begin r = {hi_e0, lo_e0}; rdv = wbrd_e0; break; end
         @(negedge clk);
      end
      check("zero_res_e0", r, 64'd0);
      check("zero_rd_e0", 64'(rdv), 64'd7);
      @(negedge clk);
      wait_idle("b2b_done_idle");

      // flush in RUN cycle 1
      issue(32'd6, 32'd7, 5'd1);
      flush_i = 1'b1;
      #1;
      check("flush_stall", {62'd0, stall_e1, stall_e0}, 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_idle", {62'd0, busy_e1, busy_e0}, 64'd0);
      pul = 0;
      for (int k = 0; k < 40; k++) begin
         if (wbv_e1 || wbv_e0) pul++;
         @(negedge clk);
      end
      check("flush_no_wb", 64'(pul), 64'd0);

      // start while busy is ignored
      issue(32'd6, 32'd7, 5'd2);
      start_i = 1'b1; op_a_i = 32'd9; op_b_i = 32'd9; rd_i = 5'd3;
      @(negedge clk);
      start_i = 1'b0;
      r = 'x; rdv = 'x;
      for (int k = 0; k < 10; k++) begin
         if (wbv_e1) begin r = {hi_e1, lo_e1}; rdv = wbrd_e1; break; end
         @(negedge clk);
      end
      check("busy_start_res", r, 64'd42);
      check("busy_start_rd", 64'(rdv), 64'd2);
      @(negedge clk);
      wait_idle("busy_start_idle");
      run_op(32'd11, 32'd13, 5'd4);

      // flush during DONE suppresses the write strobe
      issue(32'd3, 32'd5, 5'd5);
      repeat (3) @(negedge clk);
      flush_i = 1'b1;
      #1;
      check("done_flush_wbv", 64'(wbv_e1), 64'd0);
      check("done_flush_stall_e0", 64'(stall_e0), 64'd0);
      @(negedge clk);
      flush_i = 1'b0;
      check("done_flush_idle", {62'd0, busy_e1, busy_e0}, 64'd0);

      // start together with flush in IDLE is refused
      start_i = 1'b1; flush_i = 1'b1;
      #1;
      check("idle_flush_stall", {62'd0, stall_e1, stall_e0}, 64'd0);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      check("idle_flush_busy", {62'd0, busy_e1, busy_e0}, 64'd0);

      // reset during RUN cycle 2
      issue(32'd7, 32'd9, 5'd12);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_outs", {58'd0, busy_e1, busy_e0, stall_e1, stall_e0, wbv_e1, wbv_e0}, 64'd0);
      check("mid_rst_res", {hi_e1, lo_e1}, 64'd0);
      check("mid_rst_rd", {59'd0, wbrd_e0}, 64'd0);
      pul = 0;
      for (int k = 0; k < 40; k++) begin
         if (wbv_e1 || wbv_e0) pul++;
         @(negedge clk);
      end
      check("mid_rst_no_wb", 64'(pul), 64'd0);

      // randomized operands against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) rb = '0;
         run_op(ra, rb, RD_W'($urandom_range(0, 31)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
